// File: rtl/ddram_rd_pkg.sv
// Shared types and constants for the DDRAM ROM line reader.
package ddram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

  localparam int BURST_LEN_DEF = 4;
  localparam int AW_DEF        = 18;
  localparam int IDX_W         = $clog2(BURST_LEN_DEF);
  localparam int TAG_W         = AW_DEF - 3 - IDX_W;

  localparam int         DW     = 64;
  localparam logic [7:0] BE_ALL = 8'hFF;

endpackage

// File: rtl/ddram_line_buf.sv
// One cached DDRAM line: beat-indexed write port, registered indexed read with
// same-cycle write forwarding so the final burst beat can be returned directly.
module ddram_line_buf
  import ddram_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [IW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   rdata <= '0;
    else if (re)    rdata <= (we && (widx == ridx)) ? wdata : mem[ridx];
  end

endmodule

// File: rtl/ddram_rom_reader.sv
// ROM fetch responder: one-line cache in front of Avalon-MM burst reads.
// state | meaning
// IDLE  | serve hits, evaluate new or pending request
// ISSUE | DDRAM_RD held until waitrequest drops
// WAIT  | collect BURST_LEN beats into the line buffer
module ddram_rom_reader #(
  parameter logic [28:0] BASE_ADDR = 29'h0,
  parameter int          AW        = 18,
  parameter int          BURST_LEN = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [AW-1:0] ch_addr,
  input  logic          ch_req,
  output logic [63:0]   ch_dout,
  output logic          ch_ready,
  input  logic          DDRAM_BUSY,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [28:0]   DDRAM_ADDR,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic          DDRAM_WE,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE
);
  import ddram_rd_pkg::*;

  localparam int SHIFT  = $clog2(BURST_LEN);
  localparam int BEAT_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int LTAG_W = AW - 3 - SHIFT;

  rd_state_t          state, state_d;
  logic               valid, flushed, pend_v;
  logic [AW-4:0]      pend_word, eval_word;
  logic [LTAG_W-1:0]  tag_q, cur_tag, eval_tag;
  logic [BEAT_W-1:0]  beat, cur_idx, eval_idx, buf_ridx;
  logic               eval_req, hit, last_beat, deliver, buf_we, buf_re;
  logic [28:0]        line_addr;
  logic               unused_byte_sel;

  assign unused_byte_sel = ^ch_addr[2:0];

  // A fresh ch_req in IDLE overrides anything still parked in pending.
  always_comb begin
    eval_req  = 1'b0;
    eval_word = ch_addr[AW-1:3];
    if (state == IDLE) begin
      if (ch_req) begin
        eval_req = 1'b1;
      end else if (pend_v) begin
        eval_req  = 1'b1;
        eval_word = pend_word;
      end
    end
  end

  assign eval_tag  = LTAG_W'(eval_word >> SHIFT);
  assign eval_idx  = BEAT_W'(eval_word) & BEAT_W'(BURST_LEN - 1);
  assign hit       = valid && !flush && (eval_tag == tag_q);
  assign line_addr = BASE_ADDR + (29'(eval_tag) << SHIFT);
  assign buf_we    = (state == WAIT) && DDRAM_DOUT_READY;
  assign last_beat = buf_we && (beat == BEAT_W'(BURST_LEN - 1));
  assign deliver   = last_beat && !(flushed || flush || pend_v || ch_req);
  assign buf_re    = (eval_req && hit) || deliver;
  assign buf_ridx  = (state == IDLE) ? eval_idx : cur_idx;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (eval_req && !hit) state_d = ISSUE;
      ISSUE:   if (!DDRAM_BUSY)      state_d = WAIT;
      WAIT:    if (last_beat)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      flushed    <= 1'b0;
      pend_v     <= 1'b0;
      pend_word  <= '0;
      tag_q      <= '0;
      cur_tag    <= '0;
      cur_idx    <= '0;
      beat       <= '0;
      ch_ready   <= 1'b0;
      DDRAM_RD   <= 1'b0;
      DDRAM_ADDR <= '0;
    end else begin
      if (flush && (state != WAIT)) valid <= 1'b0;
      if (ch_req && (state != IDLE)) begin
        pend_v    <= 1'b1;
        pend_word <= ch_addr[AW-1:3];
        ch_ready  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (eval_req) begin
            pend_v   <= 1'b0;
            ch_ready <= hit;
            if (!hit) begin
              valid      <= 1'b0;
              flushed    <= 1'b0;
              DDRAM_RD   <= 1'b1;
              DDRAM_ADDR <= line_addr;
              cur_tag    <= eval_tag;
              cur_idx    <= eval_idx;
            end
          end
        end
        ISSUE: begin
          if (flush) flushed <= 1'b1;
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            beat     <= '0;
          end
        end
        WAIT: begin
          if (flush) flushed <= 1'b1;
          if (DDRAM_DOUT_READY) begin
            beat <= beat + 1'b1;
            // A flush seen anywhere in the fetch leaves the fresh line unusable.
            if (last_beat) begin
              tag_q    <= cur_tag;
              valid    <= !(flushed || flush);
              ch_ready <= deliver;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ddram_line_buf #(
    .DEPTH (BURST_LEN),
    .IW    (BEAT_W)
  ) u_line_buf (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .we      (buf_we),
    .widx    (beat),
    .wdata   (DDRAM_DOUT),
    .re      (buf_re),
    .ridx    (buf_ridx),
    .rdata   (ch_dout)
  );

  assign DDRAM_BURSTCNT = 8'(BURST_LEN);
  assign DDRAM_WE       = 1'b0;
  assign DDRAM_DIN      = '0;
  assign DDRAM_BE       = BE_ALL;

endmodule

// File: tb/tb_ddram_rom_reader.sv
// Bench for ddram_rom_reader: Avalon burst-read slave model over a synthetic ROM,
// table vectors, multi-cycle corner sequences and a random one-line cache model.
module tb_ddram_rom_reader;

  localparam logic [28:0] BASE = 29'h1FFF_F000;
  localparam int          AW   = 18;
  localparam int          BL   = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [AW-1:0] ch_addr;
  logic          ch_req;
  logic [63:0]   ch_dout;
  logic          ch_ready;
  logic          DDRAM_BUSY;
  logic [63:0]   DDRAM_DOUT;
  logic          DDRAM_DOUT_READY;
  logic          DDRAM_RD;
  logic [28:0]   DDRAM_ADDR;
  logic [7:0]    DDRAM_BURSTCNT;
  logic          DDRAM_WE;
  logic [63:0]   DDRAM_DIN;
  logic [7:0]    DDRAM_BE;

  ddram_rom_reader #(.BASE_ADDR(BASE), .AW(AW), .BURST_LEN(BL)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .flush            (flush),
    .ch_addr          (ch_addr),
    .ch_req           (ch_req),
    .ch_dout          (ch_dout),
    .ch_ready         (ch_ready),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    return {a, 3'b101, ~a, 3'b010};
  endfunction

  // Avalon slave model
  int          busy_hold = 0, busy_pct = 0, gap_fixed = 0, gap_rand = 0;
  int          gap_cnt, accept_cnt = 0, busy_seen = 0, last_beat_cyc = 0;
  logic [28:0] beat_q[$];
  logic [28:0] last_acc_addr = '0, prev_addr;
  logic [7:0]  last_acc_bcnt = '0;
  logic        prev_rd_busy, prev_acc;
  logic        resp_rdy, stray_rdy = 1'b0;
  logic [63:0] resp_dout, stray_dout = '0;

  assign DDRAM_DOUT_READY = resp_rdy | stray_rdy;
  assign DDRAM_DOUT       = stray_rdy ? stray_dout : resp_dout;

  initial begin
    DDRAM_BUSY = 1'b0; resp_rdy = 1'b0; resp_dout = '0; gap_cnt = 0;
    prev_rd_busy = 1'b0; prev_acc = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        beat_q.delete();
        resp_rdy = 1'b0; DDRAM_BUSY = 1'b0; prev_rd_busy = 1'b0; prev_acc = 1'b0; gap_cnt = 0;
      end else begin
        if (prev_rd_busy) chk("rd_hold", {DDRAM_RD, DDRAM_ADDR}, {1'b1, prev_addr});
        if (prev_acc)     chk("rd_drop", DDRAM_RD, 1'b0);
        resp_rdy = 1'b0;
        if (beat_q.size() > 0) begin
          if (gap_cnt > 0) gap_cnt--;
          else begin
            resp_rdy  = 1'b1;
            resp_dout = mem_word(beat_q.pop_front());
            gap_cnt   = gap_fixed + $urandom_range(0, gap_rand);
            if (beat_q.size() == 0) last_beat_cyc = cyc;
          end
        end
        if (busy_hold > 0 && DDRAM_RD) begin
          DDRAM_BUSY = 1'b1;
          busy_hold--;
        end else begin
          DDRAM_BUSY = ($urandom_range(0, 99) < busy_pct);
        end
        if (DDRAM_RD && DDRAM_BUSY) busy_seen++;
        prev_rd_busy = DDRAM_RD && DDRAM_BUSY;
        prev_addr    = DDRAM_ADDR;
        prev_acc     = DDRAM_RD && !DDRAM_BUSY;
        if (prev_acc) begin
          accept_cnt++;
          last_acc_addr = DDRAM_ADDR;
          last_acc_bcnt = DDRAM_BURSTCNT;
          for (int i = 0; i < DDRAM_BURSTCNT; i++) beat_q.push_back(DDRAM_ADDR + 29'(i));
          gap_cnt = gap_fixed + $urandom_range(0, gap_rand);
        end
      end
    end
  end

  task automatic wait_ready(input int budget);
    int w;
    w = 0;
    while (ch_ready !== 1'b1 && w < budget) begin
      @(negedge clk_sys);
      w++;
    end
  endtask

  task automatic wait_accept(input int acc0);
    int w;
    w = 0;
    while (accept_cnt == acc0 && w < 100) begin
      @(negedge clk_sys);
      w++;
    end
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic fl, input int bh, input logic miss,
                        input logic [28:0] exp_rd, input logic [28:0] exp_mem, input string nm);
    int acc0;
    acc0 = accept_cnt;
    busy_seen = 0;
    busy_hold = bh;
    @(negedge clk_sys);
    ch_addr = a; ch_req = 1'b1; flush = fl;
    @(negedge clk_sys);
    ch_req = 1'b0; flush = 1'b0;
    if (miss) begin
      chk({nm, "_drop"}, ch_ready, 1'b0);
      wait_ready(400);
      chk({nm, "_ready"}, ch_ready, 1'b1);
      chk({nm, "_lat"}, cyc, last_beat_cyc + 1);
      chk({nm, "_nacc"}, accept_cnt - acc0, 1);
      chk({nm, "_raddr"}, last_acc_addr, exp_rd);
      chk({nm, "_bcnt"}, last_acc_bcnt, BL);
      if (bh > 0) chk({nm, "_busy"}, busy_seen, bh);
    end else begin
      chk({nm, "_hit"}, ch_ready, 1'b1);
      chk({nm, "_nacc"}, accept_cnt - acc0, 0);
    end
    chk({nm, "_dout"}, ch_dout, mem_word(exp_mem));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          fl;
    int            bh;
    logic          miss;
    logic [28:0]   rd;
    logic [28:0]   mem;
    string         nm;
  } vec_t;

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acc0, w, tag, word, a;
    logic        fl, miss, m_valid;
    int          m_tag;

    vt[0] = '{18'h00010, 1'b0, 0, 1'b1, BASE,          BASE + 29'd2,  "first_miss"};
    vt[1] = '{18'h00018, 1'b0, 0, 1'b0, 29'h0,         BASE + 29'd3,  "seq_hit"};
    vt[2] = '{18'h00010, 1'b1, 0, 1'b1, BASE,          BASE + 29'd2,  "flush_req"};
    vt[3] = '{18'h00020, 1'b0, 5, 1'b1, BASE + 29'd4,  BASE + 29'd4,  "busy_miss"};
    vt[4] = '{18'h00024, 1'b0, 0, 1'b0, 29'h0,         BASE + 29'd4,  "same_word"};
    vt[5] = '{18'h3FFE0, 1'b0, 0, 1'b1, 29'h0000_6FFC, 29'h0000_6FFC, "wrap_miss"};
    vt[6] = '{18'h3FFF8, 1'b0, 0, 1'b0, 29'h0,         29'h0000_6FFF, "wrap_hit"};
    vt[7] = '{18'h00028, 1'b0, 0, 1'b1, BASE + 29'd4,  BASE + 29'd5,  "refetch"};

    reset_n = 1'b0; flush = 1'b0; ch_req = 1'b0; ch_addr = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", ch_ready, 1'b0);
    chk("rst_rd", DDRAM_RD, 1'b0);
    chk("rst_addr", DDRAM_ADDR, 29'h0);
    chk("rst_bcnt", DDRAM_BURSTCNT, BL);
    chk("rst_dout", ch_dout, 64'h0);
    chk("tie_we", DDRAM_WE, 1'b0);
    chk("tie_din", DDRAM_DIN, 64'h0);
    chk("tie_be", DDRAM_BE, 8'hFF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 8; i++)
      do_req(vt[i].addr, vt[i].fl, vt[i].bh, vt[i].miss, vt[i].rd, vt[i].mem, vt[i].nm);

    // Request parked while a burst is in flight, then serviced as its own miss.
    gap_fixed = 2;
    acc0 = accept_cnt;
    @(negedge clk_sys); ch_addr = 18'h00000; ch_req = 1'b1;
    @(negedge clk_sys); ch_req = 1'b0;
    chk("pend_drop", ch_ready, 1'b0);
    wait_accept(acc0);
    repeat (2) @(negedge clk_sys);
    ch_addr = 18'h00040; ch_req = 1'b1;
    @(negedge clk_sys); ch_req = 1'b0;
    wait_ready(400);
    chk("pend_ready", ch_ready, 1'b1);
    chk("pend_nacc", accept_cnt - acc0, 2);
    chk("pend_raddr", last_acc_addr, BASE + 29'd8);
    chk("pend_lat", cyc, last_beat_cyc + 1);
    chk("pend_dout", ch_dout, mem_word(BASE + 29'd8));

    // Flush mid-burst: line drained but never becomes valid.
    acc0 = accept_cnt;
    @(negedge clk_sys); ch_addr = 18'h00100; ch_req = 1'b1;
    @(negedge clk_sys); ch_req = 1'b0;
    wait_accept(acc0);
    repeat (2) @(negedge clk_sys);
    flush = 1'b1;
    @(negedge clk_sys); flush = 1'b0;
    w = 0;
    while (beat_q.size() > 0 && w < 200) begin @(negedge clk_sys); w++; end
    repeat (3) @(negedge clk_sys);
    chk("wflush_ready", ch_ready, 1'b0);
    chk("wflush_nacc", accept_cnt - acc0, 1);
    do_req(18'h00100, 1'b0, 0, 1'b1, BASE + 29'd32, BASE + 29'd32, "wflush_refetch");

    // Reset during WAIT, then stray beats with no outstanding read.
    acc0 = accept_cnt;
    @(negedge clk_sys); ch_addr = 18'h00200; ch_req = 1'b1;
    @(negedge clk_sys); ch_req = 1'b0;
    wait_accept(acc0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("mrst_ready", ch_ready, 1'b0);
    chk("mrst_rd", DDRAM_RD, 1'b0);
    chk("mrst_addr", DDRAM_ADDR, 29'h0);
    chk("mrst_bcnt", DDRAM_BURSTCNT, BL);
    chk("mrst_dout", ch_dout, 64'h0);
    @(negedge clk_sys); reset_n = 1'b1;
    @(negedge clk_sys); stray_rdy = 1'b1; stray_dout = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (2) @(negedge clk_sys);
    stray_rdy = 1'b0;
    @(negedge clk_sys);
    chk("stray_ready", ch_ready, 1'b0);
    chk("stray_rd", DDRAM_RD, 1'b0);
    chk("stray_dout", ch_dout, 64'h0);
    do_req(18'h00100, 1'b0, 0, 1'b1, BASE + 29'd32, BASE + 29'd32, "post_reset");

    // Random traffic against a one-line cache model over a synthetic ROM.
    busy_pct = 30; gap_fixed = 0; gap_rand = 3;
    m_valid = 1'b1; m_tag = 8;
    for (int n = 0; n < 120; n++) begin
      a    = $urandom_range(0, 191);
      fl   = ($urandom_range(0, 9) == 0);
      word = a / 8;
      tag  = word / BL;
      miss = fl || !m_valid || (m_tag != tag);
      do_req(18'(a), fl, 0, miss, 29'(BASE + tag * BL), 29'(BASE + word), "rnd");
      m_valid = 1'b1;
      m_tag   = tag;
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end

    busy_pct = 0;
    repeat (4) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
